// File: rtl/tpu_apb_pkg.sv
// Shared types and constants for the two-requester APB3 master.
package tpu_apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } apb_state_e;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   localparam logic REQ_HOST   = 1'b0;
   localparam logic REQ_LOADER = 1'b1;

   // One-hot completion vector for a requester index.
   function automatic logic [1:0] req_onehot(input logic idx);
      logic [1:0] vec;
      if (idx == REQ_LOADER) begin
         vec = 2'b10;
      end else begin
         vec = 2'b01;
      end
      return vec;
   endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin pick: i_prio names the requester that wins a tie.
module apb_rr_arbiter
   import tpu_apb_pkg::*;
(
   input  logic [1:0] i_req_valid,
   input  logic       i_prio,
   input  logic       i_enable,
   output logic       o_grant,
   output logic       o_pick
);

   // Grant index and pick strobe from the current request set.
   always_comb begin
      o_grant = REQ_HOST;
      o_pick  = i_enable & (|i_req_valid);
      if (&i_req_valid) begin
         o_grant = i_prio;
      end else if (i_req_valid[1]) begin
         o_grant = REQ_LOADER;
      end else begin
         o_grant = REQ_HOST;
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB3 master shared by two requesters with round-robin arbitration.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter
   import tpu_apb_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [1:0]          i_req_valid,
   input  logic [1:0]          i_req_write,
   input  logic [2*ADDR_W-1:0] i_req_addr,
   input  logic [2*DATA_W-1:0] i_req_wdata,
   output logic [1:0]          o_rsp_done,
   output logic [DATA_W-1:0]   o_rsp_rdata,
   output logic                o_rsp_err,
   output logic [ADDR_W-1:0]   o_paddr,
   output logic                o_psel,
   output logic                o_penable,
   output logic                o_pwrite,
   output logic [DATA_W-1:0]   o_pwdata,
   input  logic [DATA_W-1:0]   i_prdata,
   input  logic                i_pready,
   input  logic                i_pslverr
);

   apb_state_e          state_q;
   logic                prio_q;
   logic                grant_q;
   logic [1:0]          rsp_done_q;
   logic [DATA_W-1:0]   rsp_rdata_q;
   logic                rsp_err_q;
   logic [ADDR_W-1:0]   paddr_q;
   logic                psel_q;
   logic                penable_q;
   logic                pwrite_q;
   logic [DATA_W-1:0]   pwdata_q;

   logic                grant_s;
   logic                pick_s;
   logic [ADDR_W-1:0]   sel_addr_s;
   logic [DATA_W-1:0]   sel_wdata_s;
   logic                sel_write_s;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]    tmo_cnt_q;
`else
   logic                unused_timeout_s;
   assign unused_timeout_s = (TIMEOUT_CYCLES == 0);
`endif

   apb_rr_arbiter u_rr (
      .i_req_valid (i_req_valid),
      .i_prio      (prio_q),
      .i_enable    (state_q == IDLE),
      .o_grant     (grant_s),
      .o_pick      (pick_s)
   );

   // Request fields of the requester the arbiter is currently picking.
   always_comb begin
      sel_addr_s  = i_req_addr[0 +: ADDR_W];
      sel_wdata_s = i_req_wdata[0 +: DATA_W];
      sel_write_s = i_req_write[0];
      if (grant_s == REQ_LOADER) begin
         sel_addr_s  = i_req_addr[ADDR_W +: ADDR_W];
         sel_wdata_s = i_req_wdata[DATA_W +: DATA_W];
         sel_write_s = i_req_write[1];
      end else begin
         sel_addr_s  = i_req_addr[0 +: ADDR_W];
         sel_wdata_s = i_req_wdata[0 +: DATA_W];
         sel_write_s = i_req_write[0];
      end
   end

   // Transfer FSM with registered APB and response outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         prio_q      <= REQ_HOST;
         grant_q     <= REQ_HOST;
         rsp_done_q  <= 2'b00;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         paddr_q     <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
`ifdef APB_TIMEOUT_EN
         tmo_cnt_q   <= '0;
`endif
      end else begin
         rsp_done_q <= 2'b00;
         case (state_q)
            IDLE: begin
               if (pick_s) begin
                  grant_q  <= grant_s;
                  prio_q   <= ~grant_s;
                  paddr_q  <= sel_addr_s;
                  pwdata_q <= sel_wdata_s;
                  pwrite_q <= sel_write_s;
                  psel_q   <= 1'b1;
                  state_q  <= SETUP;
               end else begin
                  state_q  <= IDLE;
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ACCESS;
`ifdef APB_TIMEOUT_EN
               tmo_cnt_q <= '0;
`endif
            end
            ACCESS: begin
               if (i_pready) begin
                  rsp_rdata_q <= pwrite_q ? '0 : i_prdata;
                  rsp_err_q   <= i_pslverr;
                  rsp_done_q  <= req_onehot(grant_q);
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  state_q     <= DONE;
`ifdef APB_TIMEOUT_EN
               end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  // Limit reached without PREADY: abort the transfer as an error.
                  tmo_cnt_q   <= tmo_cnt_q + CNT_W'(1);
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b1;
                  rsp_done_q  <= req_onehot(grant_q);
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  state_q     <= DONE;
               end else begin
                  tmo_cnt_q   <= tmo_cnt_q + CNT_W'(1);
                  state_q     <= ACCESS;
`else
               end else begin
                  state_q     <= ACCESS;
`endif
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               psel_q    <= 1'b0;
               penable_q <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign o_rsp_done  = rsp_done_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_rsp_err   = rsp_err_q;
   assign o_paddr     = paddr_q;
   assign o_psel      = psel_q;
   assign o_penable   = penable_q;
   assign o_pwrite    = pwrite_q;
   assign o_pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed and randomized bench for apb_master_arbiter with a transfer-level reference model.
module tb_apb_master_arbiter;

   localparam int TMO = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       req_valid;
   logic [1:0]       req_write;
   logic [1:0][31:0] req_addr;
   logic [1:0][31:0] req_wdata;
   logic [1:0]       rsp_done;
   logic [31:0]      rsp_rdata;
   logic             rsp_err;
   logic [31:0]      paddr;
   logic             psel;
   logic             penable;
   logic             pwrite;
   logic [31:0]      pwdata;
   logic [31:0]      prdata;
   logic             pready;
   logic             pslverr;

   int n_assert = 0;
   int n_fail   = 0;
   int prio_m   = 0;

   apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .i_req_write (req_write),
      .i_req_addr  (req_addr),
      .i_req_wdata (req_wdata),
      .o_rsp_done  (rsp_done),
      .o_rsp_rdata (rsp_rdata),
      .o_rsp_err   (rsp_err),
      .o_paddr     (paddr),
      .o_psel      (psel),
      .o_penable   (penable),
      .o_pwrite    (pwrite),
      .o_pwdata    (pwdata),
      .i_prdata    (prdata),
      .i_pready    (pready),
      .i_pslverr   (pslverr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int n, input logic wr, input logic [31:0] a, input logic [31:0] d);
      req_valid[n] = 1'b1;
      req_write[n] = wr;
      req_addr[n]  = a;
      req_wdata[n] = d;
   endtask

   // One complete transfer starting in IDLE; the grant comes from the model's tie-break rule.
   task automatic xfer(input int waits, input logic slverr, input logic [31:0] rd, output int g);
      int  acc;
      bit  to;
      logic [31:0] exp_rd;
      g = (req_valid[0] && req_valid[1]) ? prio_m : (req_valid[1] ? 1 : 0);
      prio_m = 1 - g;
      acc = waits + 1;
      to  = 1'b0;
`ifdef APB_TIMEOUT_EN
      if (waits >= TMO) begin
         acc = TMO;
         to  = 1'b1;
      end
`endif
      @(posedge clk);
      @(negedge clk);
      chk("setup_psel", 32'(psel), 32'd1);
      chk("setup_penable", 32'(penable), 32'd0);
      chk("setup_paddr", paddr, req_addr[g]);
      chk("setup_pwrite", 32'(pwrite), 32'(req_write[g]));
      chk("setup_pwdata", pwdata, req_wdata[g]);
      chk("setup_done", 32'(rsp_done), 32'd0);
      @(posedge clk);
      for (int c = 0; c < acc; c++) begin
         #1;
         pready  = (c == waits);
         prdata  = (c == waits) ? rd : $urandom;
         pslverr = (c == waits) ? slverr : 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("access_psel", 32'(psel), 32'd1);
         chk("access_penable", 32'(penable), 32'd1);
         chk("access_paddr", paddr, req_addr[g]);
         chk("access_done", 32'(rsp_done), 32'd0);
         @(posedge clk);
      end
      #1;
      pready  = 1'b0;
      pslverr = 1'b0;
      exp_rd  = (to || req_write[g]) ? 32'd0 : rd;
      @(negedge clk);
      chk("done_vec", 32'(rsp_done), (g == 1) ? 32'd2 : 32'd1);
      chk("done_psel", 32'(psel), 32'd0);
      chk("done_penable", 32'(penable), 32'd0);
      chk("done_rdata", rsp_rdata, exp_rd);
      chk("done_err", 32'(rsp_err), to ? 32'd1 : 32'(slverr));
      @(posedge clk);
      #1;
      req_valid[g] = 1'b0;
      @(negedge clk);
      chk("idle_done", 32'(rsp_done), 32'd0);
      chk("idle_rdata_hold", rsp_rdata, exp_rd);
      chk("idle_paddr_hold", paddr, req_addr[g]);
   endtask

   initial begin
      int g;
      int cnt[2];
      rst_n     = 1'b0;
      req_valid = 2'b00;
      req_write = 2'b00;
      req_addr  = '0;
      req_wdata = '0;
      prdata    = 32'd0;
      pready    = 1'b0;
      pslverr   = 1'b0;
      #12;
      chk("rst_psel", 32'(psel), 32'd0);
      chk("rst_penable", 32'(penable), 32'd0);
      chk("rst_done", 32'(rsp_done), 32'd0);
      chk("rst_paddr", paddr, 32'd0);
      chk("rst_pwdata", pwdata, 32'd0);
      chk("rst_pwrite", 32'(pwrite), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Requester 0 write, no wait states.
      set_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
      xfer(0, 1'b0, 32'h5555_AAAA, g);
      chk("t1_grant", 32'(g), 32'd0);

      // Requester 1 read with three wait states.
      set_req(1, 1'b0, 32'h0000_0024, 32'h0);
      xfer(3, 1'b0, 32'h1234_5678, g);

      // Both requesters issue four random transfers each.
      cnt[0] = 0;
      cnt[1] = 0;
      set_req(0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      set_req(1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      for (int i = 0; i < 8; i++) begin
         xfer($urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom, g);
         chk("fair_grant", 32'(g), 32'(i % 2));
         cnt[g]++;
         if (cnt[g] < 4) begin
            set_req(g, 1'($urandom_range(0, 1)), $urandom, $urandom);
         end
      end

      // Slave error on a write, then a clean transfer.
      set_req(0, 1'b1, 32'h0000_00FC, 32'hCAFE_F00D);
      xfer(1, 1'b1, 32'h0, g);
      set_req(1, 1'b0, 32'h0000_0040, 32'h0);
      xfer(0, 1'b0, 32'h0BAD_F00D, g);

      // Reset in the middle of ACCESS.
      set_req(0, 1'b1, 32'h0000_0080, 32'h1111_2222);
      set_req(1, 1'b0, 32'h0000_0084, 32'h0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_penable", 32'(penable), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_psel", 32'(psel), 32'd0);
      chk("mid_rst_penable", 32'(penable), 32'd0);
      chk("mid_rst_done", 32'(rsp_done), 32'd0);
      @(negedge clk);
      chk("rst_hold_done", 32'(rsp_done), 32'd0);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      prio_m = 0;
      xfer(2, 1'b0, 32'h7777_0000, g);
      chk("post_rst_grant", 32'(g), 32'd0);
      xfer(0, 1'b0, 32'h7777_0001, g);

`ifdef APB_TIMEOUT_EN
      // Slave never ready: watchdog abort; then PREADY on the limit cycle completes normally.
      set_req(0, 1'b0, 32'h0000_0100, 32'h0);
      xfer(TMO + 4, 1'b0, 32'h9999_9999, g);
      set_req(1, 1'b0, 32'h0000_0104, 32'h0);
      xfer(TMO - 1, 1'b0, 32'h4242_4242, g);
`endif

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
